// File: rtl/dispatch_controller.sv
// dispatch_controller
//   Credit-based dispatch stall / miss controller between decode and the
//   NUM_RS reservation stations (int, bj, ls, flt with default parameters).
//   Each RS has a free-entry credit counter. Dispatch is accepted when every
//   targeted RS has a nonzero registered credit. A mispredict or misload
//   runs a fixed-length flush, after which all credits return to RS_DEPTH.
//
//   State table:
//     state | meaning
//     RUN   | normal dispatch, credits tracked per fire/release
//     FLUSH | pipeline flush in progress, dispatch stalled, credits held
//
// Ports
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   dispatch_valid in   decode presents an instruction this cycle
//   rs_dest        in   [NUM_RS] RS targets (zero-hot or multi-hot allowed)
//   rs_release     in   [NUM_RS] one entry freed in RS i this cycle
//   mispred        in   branch mispredict
//   misload        in   load misspeculation
//   stall          out  dispatch must hold its instruction
//   dispatch_fire  out  instruction accepted this cycle
//   signal_miss    out  pipeline flush request (mispred | misload)
//   flushing       out  controller is in FLUSH
//   credits        out  [NUM_RS*CW] free-entry counts, RS i at [i*CW +: CW]
//
// Optional feature, macro DISPATCH_STALL_STATS_EN:
//   stall_cycles   out  [32] cycles with dispatch_valid & stall (wraps)
//   flush_count    out  [16] RUN->FLUSH transitions (wraps)

module dispatch_controller #(
    parameter int NUM_RS       = 4,
    parameter int RS_DEPTH     = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CW           = $clog2(RS_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dispatch_valid,
    input  logic [NUM_RS-1:0]    rs_dest,
    input  logic [NUM_RS-1:0]    rs_release,
    input  logic                 mispred,
    input  logic                 misload,
    output logic                 stall,
    output logic                 dispatch_fire,
    output logic                 signal_miss,
    output logic                 flushing,
`ifdef DISPATCH_STALL_STATS_EN
    output logic [31:0]          stall_cycles,
    output logic [15:0]          flush_count,
`endif
    output logic [NUM_RS*CW-1:0] credits
);

    // Flush counter only ever holds 0 .. FLUSH_CYCLES-1.
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0]  FULL_CREDIT = CW'(RS_DEPTH);
    localparam logic [FCW-1:0] FLUSH_LOAD  = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [CW-1:0]   credit_q [NUM_RS];
    logic [CW-1:0]   credit_d [NUM_RS];

    logic            miss;
    logic [NUM_RS-1:0] zero_mask;
    logic            blocked;
    logic            stall_c;
    logic            fire_c;

    // Stall decision uses only registered credits, so a release in the
    // same cycle as a blocked dispatch does not unblock it.
    always_comb begin
        miss = mispred | misload;
        for (int i = 0; i < NUM_RS; i++) begin
            zero_mask[i] = (credit_q[i] == '0);
        end
        blocked = |(rs_dest & zero_mask);
        stall_c = (state_q == FLUSH) | miss | (dispatch_valid & blocked);
        fire_c  = dispatch_valid & ~stall_c;
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        credit_d = credit_q;
        case (state_q)
            RUN: begin
                if (miss) begin
                    // Releases in the miss cycle are discarded; credits
                    // are fully restored at the end of the flush anyway.
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end else begin
                    for (int i = 0; i < NUM_RS; i++) begin
                        credit_d[i] = credit_q[i]
                                    - CW'(fire_c & rs_dest[i])
                                    + CW'(rs_release[i] && (credit_q[i] != FULL_CREDIT));
                    end
                end
            end
            FLUSH: begin
                if (miss) begin
                    fcnt_d = FLUSH_LOAD;
                end else if (fcnt_q == '0) begin
                    state_d = RUN;
                    for (int i = 0; i < NUM_RS; i++) begin
                        credit_d[i] = FULL_CREDIT;
                    end
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            for (int i = 0; i < NUM_RS; i++) begin
                credit_q[i] <= FULL_CREDIT;
            end
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            for (int i = 0; i < NUM_RS; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign stall         = stall_c;
    assign dispatch_fire = fire_c;
    assign signal_miss   = miss;
    assign flushing      = (state_q == FLUSH);

    for (genvar g = 0; g < NUM_RS; g++) begin : g_credits
        assign credits[g*CW +: CW] = credit_q[g];
    end

`ifdef DISPATCH_STALL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (dispatch_valid & stall_c) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state_q == RUN) && miss) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A release to an RS already at full credit is dropped by saturation;
    // flag it because it usually means the RS and this block disagree.
    always @(posedge clk) begin
        if (!reset && (state_q == RUN) && !miss) begin
            for (int i = 0; i < NUM_RS; i++) begin
                assert (!(rs_release[i] && (credit_q[i] == FULL_CREDIT)))
                    else $warning("rs_release to full RS %0d dropped", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_controller.sv
module tb_dispatch_controller;

    localparam int NUM_RS = 4;
    localparam int DEPTH  = 8;
    localparam int FLUSHC = 2;
    localparam int CW     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              dispatch_valid;
    logic [NUM_RS-1:0] rs_dest;
    logic [NUM_RS-1:0] rs_release;
    logic              mispred;
    logic              misload;
    logic              stall;
    logic              dispatch_fire;
    logic              signal_miss;
    logic              flushing;
    logic [NUM_RS*CW-1:0] credits;
`ifdef DISPATCH_STALL_STATS_EN
    logic [31:0]       stall_cycles;
    logic [15:0]       flush_count;
`endif

    dispatch_controller #(
        .NUM_RS(NUM_RS), .RS_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSHC)
    ) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .rs_dest(rs_dest),
        .rs_release(rs_release), .mispred(mispred), .misload(misload),
        .stall(stall), .dispatch_fire(dispatch_fire),
        .signal_miss(signal_miss), .flushing(flushing),
`ifdef DISPATCH_STALL_STATS_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .credits(credits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers. flush_left = flush cycles still to
    // come after the current one; a miss restarts it at FLUSH_CYCLES.
    int m_credit [NUM_RS];
    int m_flush_left;
    int m_stall_cycles;
    int m_flush_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    function automatic logic [NUM_RS*CW-1:0] model_credits();
        logic [NUM_RS*CW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_RS; i++) v[i*CW +: CW] = CW'(m_credit[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_RS; i++) m_credit[i] = DEPTH;
        m_flush_left   = 0;
        m_stall_cycles = 0;
        m_flush_count  = 0;
    endtask

    // Apply one cycle of inputs at the falling edge, compare, advance model.
    task automatic step(input logic dv, input logic [NUM_RS-1:0] dest,
                        input logic [NUM_RS-1:0] rel, input logic mp, input logic ml);
        logic e_flush, e_miss, e_block, e_stall, e_fire;
        @(negedge clk);
        dispatch_valid = dv; rs_dest = dest; rs_release = rel;
        mispred = mp; misload = ml;
        #1;
        e_flush = (m_flush_left > 0);
        e_miss  = mp | ml;
        e_block = 1'b0;
        for (int i = 0; i < NUM_RS; i++) if (dest[i] && m_credit[i] == 0) e_block = 1'b1;
        e_stall = e_flush | e_miss | (dv & e_block);
        e_fire  = dv & ~e_stall;
        check("stall", stall, e_stall);
        check("fire", dispatch_fire, e_fire);
        check("signal_miss", signal_miss, e_miss);
        check("flushing", flushing, e_flush);
        check("credits", credits, model_credits());
`ifdef DISPATCH_STALL_STATS_EN
        check("stall_cycles", stall_cycles, 32'(m_stall_cycles));
        check("flush_count", flush_count, 16'(m_flush_count));
`endif
        if (dv & e_stall) m_stall_cycles++;
        if (e_miss) begin
            if (!e_flush) m_flush_count++;
            m_flush_left = FLUSHC;
        end else if (e_flush) begin
            m_flush_left--;
            if (m_flush_left == 0) for (int i = 0; i < NUM_RS; i++) m_credit[i] = DEPTH;
        end else begin
            for (int i = 0; i < NUM_RS; i++)
                m_credit[i] = m_credit[i] - int'(e_fire & dest[i])
                            + int'(rel[i] && m_credit[i] < DEPTH);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        dispatch_valid = 0; rs_dest = '0; rs_release = '0; mispred = 0; misload = 0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [NUM_RS-1:0] rnd_rel;
        reset = 1'b1;
        dispatch_valid = 0; rs_dest = '0; rs_release = '0; mispred = 0; misload = 0;
        model_reset();
        #2;
        check("rst_credits", credits, 16'h8888);
        check("rst_flushing", flushing, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_fire", dispatch_fire, 1'b0);
        check("rst_miss", signal_miss, 1'b0);
        do_reset();

        // Drain RS3: 8 fires then a stall.
        for (int k = 0; k < 8; k++) step(1, 4'b1000, 4'b0000, 0, 0);
        step(1, 4'b1000, 4'b0000, 0, 0);
        check("rs3_empty", credits[15:12], 4'd0);
        check("rs3_stall", stall, 1'b1);

        // Same-cycle release does not unblock; the next cycle fires.
        step(1, 4'b1000, 4'b1000, 0, 0);
        check("rel_same_cycle_stall", stall, 1'b1);
        step(1, 4'b1000, 4'b0000, 0, 0);
        check("rel_credit_one", credits[15:12], 4'd1);
        check("rel_then_fire", dispatch_fire, 1'b1);

        // Simultaneous fire and release; release at full is dropped.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 4'b0001, 4'b0000, 0, 0);
        step(1, 4'b0001, 4'b0001, 0, 0);
        step(0, 4'b0000, 4'b0100, 0, 0);
        check("fire_rel_hold", credits[3:0], 4'd5);
        step(0, 4'b0000, 4'b0000, 0, 0);
        check("rel_saturate", credits[11:8], 4'd8);
        step(1, 4'b0000, 4'b0000, 0, 0);
        check("zero_hot_fire", dispatch_fire, 1'b1);

        // Mispredict: stall t..t+2, flushing t+1..t+2, full credits at t+3.
        do_reset();
        step(1, 4'b1111, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0000, 1, 0);
        check("mp_t_flushing", flushing, 1'b0);
        step(1, 4'b0001, 4'b0000, 0, 0);
        check("mp_t1_flushing", flushing, 1'b1);
        step(1, 4'b0001, 4'b1111, 0, 0);
        check("mp_t2_credits_held", credits, 16'h7777);
        step(1, 4'b0001, 4'b0000, 0, 0);
        check("mp_t3_fire", dispatch_fire, 1'b1);
        check("mp_t3_credits", credits, 16'h8888);

        // Misload at t+1 extends the flush to t+3.
        step(0, 4'b0000, 4'b0000, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 1);
        step(0, 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b0010, 4'b0000, 0, 0);
        check("ml_t3_flushing", flushing, 1'b1);
        step(1, 4'b0010, 4'b0000, 0, 0);
        check("ml_t4_flushing", flushing, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            rnd_rel = NUM_RS'($urandom);
            for (int i = 0; i < NUM_RS; i++) if (m_credit[i] >= DEPTH) rnd_rel[i] = 1'b0;
            step(($urandom % 4) != 0, NUM_RS'($urandom), rnd_rel,
                 ($urandom % 40) == 0, ($urandom % 50) == 0);
        end

        // Build credits [3,0,8,2], then reset asynchronously mid-flush.
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 4'b1011, 4'b0000, 0, 0);
        step(1, 4'b1010, 4'b0000, 0, 0);
        step(1, 4'b0010, 4'b0000, 0, 0);
        step(1, 4'b0010, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0000, 1, 0);
        check("pre_rst_credits", credits, 16'h2803);
        step(0, 4'b0000, 4'b0000, 0, 0);
        check("pre_rst_flushing", flushing, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_flushing", flushing, 1'b0);
        check("async_rst_credits", credits, 16'h8888);
`ifdef DISPATCH_STALL_STATS_EN
        check("async_rst_stall_cycles", stall_cycles, 32'd0);
        check("async_rst_flush_count", flush_count, 16'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1, 4'b0001, 4'b0000, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
